// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_pkg                                                          |
// | Shared receiver state encoding, status bit positions, sel encodings. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int c_STAT_RXNE = 0;
  localparam int c_STAT_OVR  = 1;
  localparam int c_STAT_FE   = 2;

  localparam logic c_SEL_DATA   = 1'b0;
  localparam logic c_SEL_STATUS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_fifo                                                              |
// | Byte FIFO with show-ahead head; push when full and pop when empty    |
// | are ignored.                                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_fifo #(
  parameter int FIFO_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int c_DEPTH = 1 << FIFO_LOG2;

  logic [7:0]           r_mem [c_DEPTH];
  logic [FIFO_LOG2-1:0] r_wptr;
  logic [FIFO_LOG2-1:0] r_rptr;
  logic [FIFO_LOG2:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (FIFO_LOG2+1)'(c_DEPTH));
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign rdata     = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + FIFO_LOG2'(1);
      if (w_do_pop)  r_rptr <= r_rptr + FIFO_LOG2'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (FIFO_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx                                                              |
// | 8N1 serial receiver with receive FIFO and CPU data/status registers. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_LOG2    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       cs,
  input  logic       re,
  input  logic       sel,
  output logic [7:0] rdata
);

  localparam int              c_TW   = $clog2(CLKS_PER_BIT);
  localparam logic [c_TW-1:0] c_HALF = c_TW'(CLKS_PER_BIT/2 - 1);
  localparam logic [c_TW-1:0] c_FULL = c_TW'(CLKS_PER_BIT - 1);

  logic            r_sync1;
  logic            r_rxs;
  rx_state_t       r_state, w_state_nxt;
  logic [c_TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            w_push;
  logic            w_fe_set;
  logic            r_fe;
  logic            r_ovr;
  logic [7:0]      w_fifo_rdata;
  logic            w_empty;
  logic            w_full;
  logic            w_rd_data;
  logic            w_rd_stat;
  logic [7:0]      w_status;

  assign w_rd_data = cs & re & (sel == c_SEL_DATA);
  assign w_rd_stat = cs & re & (sel == c_SEL_STATUS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Every sampling state counts the timer down and acts only when it reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_fe_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = ST_START;
          w_timer_nxt = c_HALF;
        end
      end
      ST_START: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - c_TW'(1);
        end else if (!r_rxs) begin
          w_state_nxt = ST_DATA;
          w_timer_nxt = c_FULL;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - c_TW'(1);
        end else begin
          w_shift_nxt[r_idx] = r_rxs;
          w_timer_nxt        = c_FULL;
          if (r_idx == 3'd7) w_state_nxt = ST_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - c_TW'(1);
        end else if (r_rxs) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_fe_set    = 1'b1;
          w_state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (r_rxs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  rx_fifo #(
    .FIFO_LOG2(FIFO_LOG2)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (w_push),
    .pop  (w_rd_data & ~w_empty),
    .wdata(r_shift),
    .rdata(w_fifo_rdata),
    .empty(w_empty),
    .full (w_full)
  );

  always_comb begin
    w_status              = 8'h00;
    w_status[c_STAT_RXNE] = ~w_empty;
    w_status[c_STAT_OVR]  = r_ovr;
    w_status[c_STAT_FE]   = r_fe;
  end

  // Setting a flag takes priority over the clear-on-status-read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fe  <= 1'b0;
      r_ovr <= 1'b0;
      rdata <= 8'h00;
    end else begin
      if (w_fe_set)             r_fe <= 1'b1;
      else if (w_rd_stat)       r_fe <= 1'b0;
      if (w_push && w_full)     r_ovr <= 1'b1;
      else if (w_rd_stat)       r_ovr <= 1'b0;
      if (w_rd_data)            rdata <= w_empty ? 8'h00 : w_fifo_rdata;
      else if (w_rd_stat)       rdata <= w_status;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx                                                           |
// | Directed and random frames checked against a queue-based model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       cs;
  logic       re;
  logic       sel;
  logic [7:0] rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       m_fe;
  logic       m_ovr;
  logic [7:0] last_exp;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(16),
    .FIFO_LOG2   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .cs   (cs),
    .re   (re),
    .sel  (sel),
    .rdata(rdata)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() >= 4) m_ovr = 1'b1;
    else               q.push_back(b);
  endtask

  // Called at a falling clock edge; one bit lasts 16 clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    if (stop) model_push(b);
    else      m_fe = 1'b1;
  endtask

  task automatic do_read(input logic s, output logic [7:0] d);
    cs  = 1'b1;
    re  = 1'b1;
    sel = s;
    @(negedge clk);
    cs = 1'b0;
    re = 1'b0;
    d  = rdata;
  endtask

  task automatic read_data(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    do_read(1'b0, d);
    if (q.size() != 0) exp = q.pop_front();
    else               exp = 8'h00;
    last_exp = exp;
    check(tag, d, exp);
  endtask

  task automatic read_status(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    do_read(1'b1, d);
    exp      = {5'b0, m_fe, m_ovr, q.size() != 0};
    m_fe     = 1'b0;
    m_ovr    = 1'b0;
    last_exp = exp;
    check(tag, d, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] frag;
    int         r;

    reset = 1'b1;
    rx    = 1'b1;
    cs    = 1'b0;
    re    = 1'b0;
    sel   = 1'b0;
    m_fe  = 1'b0;
    m_ovr = 1'b0;
    last_exp = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_rdata", rdata, 8'h00);
    read_status("reset_status");
    read_data("reset_data_empty");
    repeat (4) @(negedge clk);

    // Single byte
    send_frame(8'h41, 1'b1);
    read_status("single_status");
    read_data("single_data");
    repeat (6) @(negedge clk);
    check("rdata_hold", rdata, last_exp);
    read_status("single_status_after");

    // Overflow: five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    read_status("ovr_status");
    for (int i = 0; i < 4; i++) read_data("ovr_data");
    read_status("ovr_status_after");
    read_data("ovr_data_empty");

    // Framing error followed by a long break
    send_frame(8'h55, 1'b0);
    repeat (24) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    read_status("fe_status");
    read_status("fe_status_clear");
    send_frame(8'hA5, 1'b1);
    read_data("fe_next_data");

    // Short glitch on rx is rejected
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    read_status("glitch_status");
    read_data("glitch_data");

    // Data read lands on the stop-bit sample edge of the next frame
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (154) @(negedge clk);
        read_data("stop_edge_old");
      end
    join
    read_status("stop_edge_status");
    read_data("stop_edge_new");

    // Reset in the middle of bit 3
    frag = 8'h5A;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = frag[i];
      repeat (16) @(negedge clk);
    end
    rx = frag[3];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    q.delete();
    m_fe  = 1'b0;
    m_ovr = 1'b0;
    check("midframe_reset_rdata", rdata, 8'h00);
    repeat (200) @(negedge clk);
    read_status("midframe_status");
    send_frame(8'h3C, 1'b1);
    read_data("midframe_next_data");

    // Random bytes with random interleaved reads
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      r = $urandom_range(0, 3);
      if (r == 0) read_data("rand_data");
      else if (r == 1) read_status("rand_status");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    read_status("rand_drain_status");
    for (int i = 0; i < 5; i++) read_data("rand_drain_data");
    read_status("rand_final_status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (even, >=4).
REQ-002 SHALL have parameter FIFO_LOG2, default 2, meaning receive FIFO depth of 2**FIFO_LOG2 bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 SHALL have port cs  input  1  chip select, driven by CPU decode of d_addr[31:28]==4'hE.
REQ-007 SHALL have port re  input  1  read strobe; an access is cs & re.
REQ-008 SHALL have port sel  input  1  register select: 0 = data, 1 = status (CPU drives d_addr[2]).
REQ-009 SHALL have port rdata  output  8  registered read data, presented on the CPU d_data_r low byte.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized value rxs.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK with one bit-timer counter and a 3-bit bit index.
REQ-012 IDLE: on rxs==0 SHALL go to START with timer = CLKS_PER_BIT/2-1.
REQ-013 START: at timer==0, rxs==0 -> DATA with timer = CLKS_PER_BIT-1, bit index 0; rxs==1 -> IDLE (glitch rejected, nothing recorded).
REQ-014 DATA: at each timer==0 SHALL shift rxs into bit[index], reload timer; after bit 7 go to STOP.
REQ-015 STOP: at timer==0, rxs==1 -> push byte, go IDLE; rxs==0 -> discard byte, set sticky FE, go BREAK.
REQ-016 BREAK: SHALL wait for rxs==1, then go IDLE.
REQ-017 A push with FIFO full SHALL drop the new byte, keep FIFO contents, set sticky OVR.
REQ-018 Access cs&re&sel==0: rdata <= FIFO head and pop on the same edge; if empty, rdata <= 8'h00, no pointer change.
REQ-019 Access cs&re&sel==1: rdata <= {5'b0, FE, OVR, !empty}; FE and OVR SHALL clear on that edge.
REQ-020 A flag set and a status read on the same edge SHALL leave the flag set (set wins).
REQ-021 Push and pop on the same edge SHALL both occur; count unchanged; a push into an empty FIFO is not poppable until the next edge.
REQ-022 Read latency SHALL be one clock (rdata valid the cycle after the access, matching dualsyncram); rdata holds its value when there is no access.
REQ-023 FIFO pointers SHALL be FIFO_LOG2 bits with natural wrap; full/empty SHALL use a FIFO_LOG2+1-bit count.

Reset
REQ-024 reset SHALL force state IDLE, timer 0, index 0, synchronizer flops 1, FIFO empty, FE=0, OVR=0, rdata=8'h00.
REQ-025 reset mid-frame SHALL abort the frame with no push; reception restarts at the next falling edge after reset deasserts.

Structure
REQ-026 A shared package SHALL hold the state enum, the status bit positions (RXNE=0, OVR=1, FE=2) and the data/status sel encodings.
REQ-027 The FIFO SHALL be a sub-module rx_fifo (parameter FIFO_LOG2; push, pop, wdata, rdata, empty, full).

Verification (CLKS_PER_BIT=16, FIFO_LOG2=2)
REQ-028 Send 0x41 -> status read 0x01, data read 0x41, status read 0x00.
REQ-029 Send 0x01,0x02,0x03,0x04,0x05 with no reads -> status 0x03, data reads 0x01..0x04, then status 0x00, then data read 0x00.
REQ-030 Send 0x55 with stop bit 0, rx held low 40 clocks, then high -> no push, status 0x04, then 0x00; a following 0xA5 is received correctly.
REQ-031 rx low for 4 clocks, then high -> state returns to IDLE, status 0x00.
REQ-032 FIFO holding 1 byte, data read issued on the STOP-bit sample edge of a new 0x7E -> old byte returned, status then 0x01, next data read 0x7E.
REQ-033 reset pulsed during bit 3 of a frame -> status 0x00 after reset, next full frame 0x3C received as 0x3C.
